// File: rtl/tinyqv_mem_pkg.sv
// tinyqv_mem_pkg
// Shared types and constants for the TinyQV memory arbiter.
//   arb_state_t  : arbiter FSM states
//   SIZE_*       : data_size encoding from the core (2'b11 also means word)
//   LEN_*        : nibble counts handed to the memory controller
//   size_to_len  : data_size -> nibble count
package tinyqv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] LEN_BYTE  = 4'd2;
  localparam logic [3:0] LEN_HALF  = 4'd4;
  localparam logic [3:0] LEN_WORD  = 4'd8;
  localparam logic [3:0] LEN_FETCH = 4'd4;

  function automatic logic [3:0] size_to_len(input logic [1:0] size);
    case (size)
      SIZE_BYTE:        return LEN_BYTE;
      SIZE_HALF:        return LEN_HALF;
      SIZE_WORD, 2'b11: return LEN_WORD;
      default:          return LEN_WORD;
    endcase
  endfunction

endpackage

// File: rtl/tinyqv_mem_arbiter_if.sv
// tinyqv_mem_arbiter_if
// Nibble-serial memory controller port.
//   master : arbiter side (drives start/addr/write/len/wdata)
//   slave  : controller side (drives wnext/rdata/rvalid/busy/done)
interface tinyqv_mem_arbiter_if #(
  parameter int ADDR_BITS = 24
) ();
  logic                 mem_start;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_write;
  logic [3:0]           mem_len;
  logic [3:0]           mem_wdata;
  logic                 mem_wnext;
  logic [3:0]           mem_rdata;
  logic                 mem_rvalid;
  logic                 mem_busy;
  logic                 mem_done;

  modport master (
    output mem_start, mem_addr, mem_write, mem_len, mem_wdata,
    input  mem_wnext, mem_rdata, mem_rvalid, mem_busy, mem_done
  );

  modport slave (
    input  mem_start, mem_addr, mem_write, mem_len, mem_wdata,
    output mem_wnext, mem_rdata, mem_rvalid, mem_busy, mem_done
  );
endinterface

// File: rtl/tinyqv_store_buffer.sv
// tinyqv_store_buffer
// 32-bit store data shift register.
//   clk, rstn  : clock, synchronous active-low reset
//   capture    : shift wdata_in in at the top (core streams store data)
//   drain      : shift right one nibble (controller consumed a nibble)
//   wdata_in   : core store nibble
//   len        : nibble count of the current store (2, 4 or 8)
//   wdata_out  : nibble currently offered to the controller
module tinyqv_store_buffer (
  input  logic       clk,
  input  logic       rstn,
  input  logic       capture,
  input  logic       drain,
  input  logic [3:0] wdata_in,
  input  logic [3:0] len,
  output logic [3:0] wdata_out
);

  logic [31:0] wbuf;
  logic [3:0]  first_nib;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wbuf <= '0;
    end else if (capture) begin
      wbuf <= {wdata_in, wbuf[31:4]};
    end else if (drain) begin
      wbuf <= {4'h0, wbuf[31:4]};
    end
  end

  // The most recent nibbles sit at the top, so a short store starts
  // (8 - len) nibbles up; draining moves the next nibble into that slot.
  assign first_nib = 4'd8 - len;
  assign wdata_out = wbuf[{first_nib[2:0], 2'b00} +: 4];

endmodule

// File: rtl/tinyqv_mem_arbiter.sv
// tinyqv_mem_arbiter
// Shares the nibble-serial memory controller between instruction fetch and
// the core load/store path. Pending data accesses win over fetches.
//   clk, rstn              : clock, synchronous active-low reset
//   instr_req/addr/flush   : fetch request (level), address, branch cancel
//   instr_rdata/valid      : fetched 16-bit parcel, one-cycle valid pulse
//   data_req/addr/write/size/wdata : core access pulse and store nibble stream
//   data_rdata/rvalid      : load nibbles straight from the controller
//   data_done/busy         : completion pulse, access pending/active
//   mem                    : controller port (master modport)
// Build option TINYQV_POSTED_STORE_EN: stores report data_done the cycle
// after data_req while the write drains in the background.
//
// state    | meaning
// ST_IDLE  | no transaction; choose data (pending or new) over fetch
// ST_FETCH | fetch transaction running, assembling instr parcel
// ST_DATA  | load/store transaction running
module tinyqv_mem_arbiter #(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 instr_req,
  input  logic [ADDR_BITS-1:0] instr_addr,
  input  logic                 instr_flush,
  output logic [15:0]          instr_rdata,
  output logic                 instr_valid,
  input  logic                 data_req,
  input  logic [ADDR_BITS-1:0] data_addr,
  input  logic                 data_write,
  input  logic [1:0]           data_size,
  input  logic [3:0]           data_wdata,
  output logic [3:0]           data_rdata,
  output logic                 data_rvalid,
  output logic                 data_done,
  output logic                 data_busy,
  tinyqv_mem_arbiter_if.master mem
);
  import tinyqv_mem_pkg::*;

`ifdef TINYQV_POSTED_STORE_EN
  localparam bit POSTED_STORE = 1'b1;
`else
  localparam bit POSTED_STORE = 1'b0;
`endif

  arb_state_t           state, state_next;
  logic                 start_data, start_fetch;
  logic                 accept;
  logic                 data_pend, busy_q, fetch_discard;
  logic [ADDR_BITS-1:0] pend_addr;
  logic                 pend_write;
  logic [3:0]           pend_len;
  logic [15:0]          fetch_buf, fetch_next;
  logic [3:0]           sb_wdata;
  logic                 in_data;

  assign accept    = data_req && !busy_q;
  assign data_busy = busy_q;
  assign in_data   = (state == ST_DATA);

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_data  = 1'b0;
    start_fetch = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!mem.mem_busy) begin
          if (data_pend || accept) begin
            start_data = 1'b1;
            state_next = ST_DATA;
          end else if (instr_req && !instr_flush && !instr_valid) begin
            // instr_req may still be high in the instr_valid cycle for the
            // parcel just delivered, so do not refetch it.
            start_fetch = 1'b1;
            state_next  = ST_FETCH;
          end
        end
      end
      ST_FETCH, ST_DATA: begin
        if (mem.mem_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fetch_next = mem.mem_rvalid ? {mem.mem_rdata, fetch_buf[15:4]} : fetch_buf;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem.mem_start <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_write <= 1'b0;
      mem.mem_len   <= 4'd0;
      data_pend     <= 1'b0;
      busy_q        <= 1'b0;
      pend_addr     <= '0;
      pend_write    <= 1'b0;
      pend_len      <= 4'd0;
      data_done     <= 1'b0;
      fetch_discard <= 1'b0;
      fetch_buf     <= 16'h0;
      instr_rdata   <= 16'h0;
      instr_valid   <= 1'b0;
    end else begin
      mem.mem_start <= start_data || start_fetch;
      data_done     <= 1'b0;
      instr_valid   <= 1'b0;

      if (start_data) begin
        mem.mem_addr  <= data_pend ? pend_addr  : data_addr;
        mem.mem_write <= data_pend ? pend_write : data_write;
        mem.mem_len   <= data_pend ? pend_len   : size_to_len(data_size);
      end else if (start_fetch) begin
        mem.mem_addr  <= instr_addr;
        mem.mem_write <= 1'b0;
        mem.mem_len   <= LEN_FETCH;
      end

      if (accept) begin
        pend_addr  <= data_addr;
        pend_write <= data_write;
        pend_len   <= size_to_len(data_size);
      end

      if (start_data)  data_pend <= 1'b0;
      else if (accept) data_pend <= 1'b1;

      if (accept)                      busy_q <= 1'b1;
      else if (in_data && mem.mem_done) busy_q <= 1'b0;

      if (POSTED_STORE && accept && data_write) data_done <= 1'b1;
      if (in_data && mem.mem_done && !(POSTED_STORE && mem.mem_write)) data_done <= 1'b1;

      if (state == ST_FETCH) begin
        fetch_buf <= fetch_next;
        if (instr_flush) fetch_discard <= 1'b1;
        if (mem.mem_done) begin
          fetch_discard <= 1'b0;
          if (!fetch_discard && !instr_flush) begin
            instr_rdata <= fetch_next;
            instr_valid <= 1'b1;
          end
        end
      end else begin
        fetch_discard <= 1'b0;
      end
    end
  end

  tinyqv_store_buffer u_store_buffer (
    .clk       (clk),
    .rstn      (rstn),
    .capture   (!busy_q),
    .drain     (in_data && mem.mem_write && mem.mem_wnext),
    .wdata_in  (data_wdata),
    .len       (mem.mem_len),
    .wdata_out (sb_wdata)
  );

  assign mem.mem_wdata = (in_data && mem.mem_write) ? sb_wdata : 4'h0;
  assign data_rvalid   = in_data && !mem.mem_write && mem.mem_rvalid;
  assign data_rdata    = data_rvalid ? mem.mem_rdata : 4'h0;

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
module tb_tinyqv_mem_arbiter;
  localparam int AB = 24;

`ifdef TINYQV_POSTED_STORE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic          clk, rstn;
  logic          instr_req, instr_flush;
  logic [AB-1:0] instr_addr, data_addr;
  logic [15:0]   instr_rdata;
  logic          instr_valid;
  logic          data_req, data_write;
  logic [1:0]    data_size;
  logic [3:0]    data_wdata, data_rdata;
  logic          data_rvalid, data_done, data_busy;
  logic [3:0]    nib [0:7];

  int checks   = 0;
  int failures = 0;

  tinyqv_mem_arbiter_if #(.ADDR_BITS(AB)) mem_if ();

  tinyqv_mem_arbiter #(.ADDR_BITS(AB)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_flush (instr_flush),
    .instr_rdata (instr_rdata),
    .instr_valid (instr_valid),
    .data_req    (data_req),
    .data_addr   (data_addr),
    .data_write  (data_write),
    .data_size   (data_size),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_rvalid (data_rvalid),
    .data_done   (data_done),
    .data_busy   (data_busy),
    .mem         (mem_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Controller returns n read nibbles from nib[], done on the last one.
  task automatic feed_reads(input int n, input bit pass, input bit flush_last, input string tag);
    for (int i = 0; i < n; i++) begin
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = nib[i];
      mem_if.mem_done   = (i == n - 1);
      if (flush_last && i == n - 1) begin
        instr_flush = 1'b1;
        instr_req   = 1'b0;
      end
      #1;
      if (pass) chk(tag, 32'({data_rvalid, data_rdata}), 32'({1'b1, nib[i]}));
      else      chk(tag, 32'(data_rvalid), 32'd0);
      cyc();
    end
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = 4'h0;
    mem_if.mem_done   = 1'b0;
    mem_if.mem_busy   = 1'b0;
    instr_flush       = 1'b0;
  endtask

  // Controller consumes n write nibbles, expecting nib[] in order.
  task automatic feed_writes(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk(tag, 32'(mem_if.mem_wdata), 32'(nib[i]));
      mem_if.mem_wnext = 1'b1;
      mem_if.mem_done  = (i == n - 1);
      data_wdata       = ~nib[i];
      cyc();
    end
    mem_if.mem_wnext = 1'b0;
    mem_if.mem_done  = 1'b0;
    mem_if.mem_busy  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    instr_req = 1'b0; instr_flush = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_write = 1'b0; data_size = 2'b00; data_addr = '0; data_wdata = 4'h0;
    mem_if.mem_wnext = 1'b0; mem_if.mem_rdata = 4'h0; mem_if.mem_rvalid = 1'b0;
    mem_if.mem_busy = 1'b0; mem_if.mem_done = 1'b0;
    for (int i = 0; i < 8; i++) nib[i] = 4'h0;

    // reset
    cyc(); cyc(); cyc();
    chk("rst_start", 32'(mem_if.mem_start), 0);
    chk("rst_addr", 32'(mem_if.mem_addr), 0);
    chk("rst_len", 32'(mem_if.mem_len), 0);
    chk("rst_ivalid", 32'(instr_valid), 0);
    chk("rst_irdata", 32'(instr_rdata), 0);
    chk("rst_dbusy", 32'(data_busy), 0);
    chk("rst_ddone", 32'(data_done), 0);
    rstn = 1'b1;
    cyc();

    // load word 0x000100
    data_req = 1'b1; data_addr = 24'h000100; data_write = 1'b0; data_size = 2'b10;
    cyc();
    data_req = 1'b0;
    chk("ld_start", 32'(mem_if.mem_start), 1);
    chk("ld_addr", 32'(mem_if.mem_addr), 32'h100);
    chk("ld_write", 32'(mem_if.mem_write), 0);
    chk("ld_len", 32'(mem_if.mem_len), 8);
    chk("ld_busy", 32'(data_busy), 1);
    cyc();
    mem_if.mem_busy = 1'b1;
    chk("ld_start_pulse", 32'(mem_if.mem_start), 0);
    nib[0] = 4'h4; nib[1] = 4'h3; nib[2] = 4'h2; nib[3] = 4'h1;
    nib[4] = 4'h8; nib[5] = 4'h7; nib[6] = 4'h6; nib[7] = 4'h5;
    feed_reads(8, 1'b1, 1'b0, "ld_rnib");
    chk("ld_done", 32'(data_done), 1);
    chk("ld_busy_fall", 32'(data_busy), 0);
    cyc();
    chk("ld_done_pulse", 32'(data_done), 0);

    // store half, stream ends A,B,C,D at data_req
    for (int i = 1; i <= 12; i++) begin
      data_wdata = 4'(i);
      cyc();
    end
    data_wdata = 4'hD;
    data_req = 1'b1; data_addr = 24'h002002; data_write = 1'b1; data_size = 2'b01;
    cyc();
    data_req = 1'b0; data_wdata = 4'h5;
    chk("sth_start", 32'(mem_if.mem_start), 1);
    chk("sth_write", 32'(mem_if.mem_write), 1);
    chk("sth_len", 32'(mem_if.mem_len), 4);
    chk("sth_addr", 32'(mem_if.mem_addr), 32'h2002);
    chk("sth_posted_done", 32'(data_done), 32'(POSTED));
    cyc();
    mem_if.mem_busy = 1'b1;
    nib[0] = 4'hA; nib[1] = 4'hB; nib[2] = 4'hC; nib[3] = 4'hD;
    feed_writes(4, "sth_wdata");
    chk("sth_done", 32'(data_done), 32'(!POSTED));
    chk("sth_busy_fall", 32'(data_busy), 0);

    // fetch and load requested together: data first
    instr_req = 1'b1; instr_addr = 24'h000400;
    data_req = 1'b1; data_addr = 24'h000055; data_write = 1'b0; data_size = 2'b00;
    cyc();
    data_req = 1'b0;
    chk("pri_start", 32'(mem_if.mem_start), 1);
    chk("pri_addr", 32'(mem_if.mem_addr), 32'h55);
    chk("pri_len", 32'(mem_if.mem_len), 2);
    cyc();
    mem_if.mem_busy = 1'b1;
    nib[0] = 4'h9; nib[1] = 4'h6;
    feed_reads(2, 1'b1, 1'b0, "pri_rnib");
    chk("pri_done", 32'(data_done), 1);
    chk("pri_gap", 32'(mem_if.mem_start), 0);
    cyc();
    chk("fe_start", 32'(mem_if.mem_start), 1);
    chk("fe_addr", 32'(mem_if.mem_addr), 32'h400);
    chk("fe_len", 32'(mem_if.mem_len), 4);
    chk("fe_write", 32'(mem_if.mem_write), 0);
    cyc();
    mem_if.mem_busy = 1'b1;
    nib[0] = 4'h4; nib[1] = 4'h3; nib[2] = 4'h2; nib[3] = 4'h1;
    feed_reads(4, 1'b0, 1'b0, "fe_no_drvalid");
    chk("fe_valid", 32'(instr_valid), 1);
    chk("fe_rdata", 32'(instr_rdata), 32'h1234);
    instr_req = 1'b0;
    cyc();
    chk("fe_valid_pulse", 32'(instr_valid), 0);

    // flush mid-fetch
    instr_req = 1'b1; instr_addr = 24'h000800;
    cyc();
    chk("fl_start", 32'(mem_if.mem_start), 1);
    chk("fl_addr", 32'(mem_if.mem_addr), 32'h800);
    cyc();
    mem_if.mem_busy = 1'b1;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 4'hE;
    cyc();
    mem_if.mem_rdata = 4'hF; instr_flush = 1'b1; instr_req = 1'b0;
    cyc();
    instr_flush = 1'b0;
    nib[0] = 4'h7; nib[1] = 4'h7;
    feed_reads(2, 1'b0, 1'b0, "fl_no_drvalid");
    chk("fl_no_valid", 32'(instr_valid), 0);
    chk("fl_rdata_held", 32'(instr_rdata), 32'h1234);
    instr_req = 1'b1; instr_addr = 24'h000900;
    cyc();
    chk("fl_refetch_start", 32'(mem_if.mem_start), 1);
    chk("fl_refetch_addr", 32'(mem_if.mem_addr), 32'h900);
    cyc();
    mem_if.mem_busy = 1'b1;
    nib[0] = 4'hD; nib[1] = 4'hC; nib[2] = 4'hB; nib[3] = 4'hA;
    feed_reads(4, 1'b0, 1'b0, "fl_refetch");
    chk("fl_refetch_valid", 32'(instr_valid), 1);
    chk("fl_refetch_rdata", 32'(instr_rdata), 32'hABCD);
    instr_req = 1'b0;
    cyc();

    // flush on the final-nibble cycle
    instr_req = 1'b1; instr_addr = 24'h000A00;
    cyc();
    chk("fll_start", 32'(mem_if.mem_start), 1);
    cyc();
    mem_if.mem_busy = 1'b1;
    nib[0] = 4'h1; nib[1] = 4'h2; nib[2] = 4'h3; nib[3] = 4'h4;
    feed_reads(4, 1'b0, 1'b1, "fll_no_drvalid");
    chk("fll_no_valid", 32'(instr_valid), 0);
    chk("fll_rdata_held", 32'(instr_rdata), 32'hABCD);

    // fetch with flush in the same idle cycle is not issued
    instr_req = 1'b1; instr_flush = 1'b1; instr_addr = 24'h000B00;
    cyc();
    chk("idle_flush_nostart", 32'(mem_if.mem_start), 0);
    instr_req = 1'b0; instr_flush = 1'b0;
    cyc();

    // store word; second data_req during drain ignored
    for (int i = 1; i <= 7; i++) begin
      data_wdata = 4'(i);
      cyc();
    end
    data_wdata = 4'h8;
    data_req = 1'b1; data_addr = 24'h003000; data_write = 1'b1; data_size = 2'b10;
    cyc();
    data_req = 1'b0;
    chk("stw_start", 32'(mem_if.mem_start), 1);
    chk("stw_len", 32'(mem_if.mem_len), 8);
    chk("stw_posted_done", 32'(data_done), 32'(POSTED));
    chk("stw_busy", 32'(data_busy), 1);
    cyc();
    chk("stw_done_pulse", 32'(data_done), 0);
    mem_if.mem_busy = 1'b1;
    data_req = 1'b1; data_write = 1'b0; data_addr = 24'h007777; data_size = 2'b00;
    chk("stw_wdata0", 32'(mem_if.mem_wdata), 1);
    mem_if.mem_wnext = 1'b1;
    cyc();
    data_req = 1'b0;
    for (int i = 0; i < 7; i++) nib[i] = 4'(i + 2);
    feed_writes(7, "stw_wdata");
    chk("stw_done", 32'(data_done), 32'(!POSTED));
    chk("stw_busy_fall", 32'(data_busy), 0);
    cyc();
    chk("stw_ignored_req", 32'(mem_if.mem_start), 0);
    chk("stw_no_pend", 32'(data_busy), 0);

    // reset in the middle of a load
    data_req = 1'b1; data_addr = 24'h000123; data_write = 1'b0; data_size = 2'b10;
    cyc();
    data_req = 1'b0;
    chk("mrst_start", 32'(mem_if.mem_start), 1);
    cyc();
    mem_if.mem_busy = 1'b1;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 4'h3;
    cyc();
    mem_if.mem_rdata = 4'h4;
    cyc();
    rstn = 1'b0; mem_if.mem_busy = 1'b0; mem_if.mem_rdata = 4'h5;
    cyc();
    chk("mrst_start0", 32'(mem_if.mem_start), 0);
    chk("mrst_addr0", 32'(mem_if.mem_addr), 0);
    chk("mrst_len0", 32'(mem_if.mem_len), 0);
    chk("mrst_busy0", 32'(data_busy), 0);
    chk("mrst_rvalid0", 32'({data_rvalid, data_rdata}), 0);
    chk("mrst_irdata0", 32'(instr_rdata), 0);
    rstn = 1'b1; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 4'h0;
    cyc();
    data_req = 1'b1; data_addr = 24'h000044; data_write = 1'b0; data_size = 2'b00;
    cyc();
    data_req = 1'b0;
    chk("post_rst_start", 32'(mem_if.mem_start), 1);
    chk("post_rst_addr", 32'(mem_if.mem_addr), 32'h44);
    chk("post_rst_len", 32'(mem_if.mem_len), 2);
    cyc();
    mem_if.mem_busy = 1'b1;
    nib[0] = 4'h6; nib[1] = 4'h9;
    feed_reads(2, 1'b1, 1'b0, "post_rst_rnib");
    chk("post_rst_done", 32'(data_done), 1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
